// File: rtl/soml_pkg.sv
// Shared types and helpers for the SOML decoder datapath: FSM states, width
// arithmetic and the result saturation/wrap conversion used by several blocks.
package soml_pkg;

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  // Conversion operates at a fixed wide width so one function serves all callers.
  localparam int CONV_W = 64;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int len_w(input int max_len);
    return clog2(max_len + 1);
  endfunction

  function automatic int acc_w(input int data_w, input int max_len);
    return data_w + clog2(max_len);
  endfunction

  // Returns {ovf, value}; value is x clamped (sat=1) or reduced to its low out_w
  // bits and sign-extended back (sat=0).
  function automatic logic [CONV_W:0] sat_wrap(input logic signed [CONV_W-1:0] x,
                                                input int out_w, input logic sat);
    logic signed [CONV_W-1:0] hi;
    logic signed [CONV_W-1:0] lo;
    logic signed [CONV_W-1:0] w;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (sat) begin
      if (x > hi) return {1'b1, hi};
      if (x < lo) return {1'b1, lo};
      return {1'b0, x};
    end
    w = (x <<< (CONV_W - out_w)) >>> (CONV_W - out_w);
    return {(w != x), w};
  endfunction

endpackage

// File: rtl/soml_accum_lane.sv
// One accumulation lane: full-width signed accumulator plus conversion of the
// running sum (including the sample presented this cycle) to the result width.
module soml_accum_lane import soml_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 20,
  parameter int OUT_W  = 20,
  parameter int SAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     add,
  input  logic signed [DATA_W-1:0] sdi,
  output logic signed [OUT_W-1:0]  res,
  output logic                     ovf
);

  logic signed [ACC_W-1:0] acc_p0;
  logic signed [ACC_W-1:0] sum;
  logic [CONV_W:0]         conv;
  logic                    unused_conv;

  assign sum = acc_p0 + {{(ACC_W-DATA_W){sdi[DATA_W-1]}}, sdi};

  // Stage p0: accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc_p0 <= '0;
    else if (clr) acc_p0 <= '0;
    else if (add) acc_p0 <= sum;
  end

  assign conv        = sat_wrap({{(CONV_W-ACC_W){sum[ACC_W-1]}}, sum}, OUT_W, SAT != 0);
  assign res         = conv[OUT_W-1:0];
  assign ovf         = conv[CONV_W];
  assign unused_conv = ^conv[CONV_W-1:OUT_W];

endmodule

// File: rtl/soml_accum.sv
// Multi-lane signed sample accumulator: counts a programmable number of valid
// sample sets after start, then publishes per-lane results with an out_valid pulse.
module soml_accum import soml_pkg::*; #(
  parameter int DATA_W  = 16,
  parameter int LANES   = 4,
  parameter int MAX_LEN = 16,
  parameter int OUT_W   = 20,
  parameter int SAT     = 1,
  localparam int LEN_W  = len_w(MAX_LEN),
  localparam int ACC_W  = acc_w(DATA_W, MAX_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    in_valid,
  input  logic [LANES*DATA_W-1:0] sdi,
  output logic                    in_ready,
  output logic [LANES*OUT_W-1:0]  out,
  output logic [LANES-1:0]        ovf,
  output logic                    out_valid,
  output logic                    len_err
);

  state_t                 state;
  state_t                 state_nxt;
  logic [LEN_W-1:0]       cnt;
  logic                   len_ok;
  logic                   load;
  logic                   accept;
  logic                   last;
  logic [LANES*OUT_W-1:0] res;
  logic [LANES-1:0]       res_ovf;

  assign len_ok = (len != '0) && (len <= LEN_W'(MAX_LEN));
  assign load   = start && len_ok;
  // A start always wins over a sample presented in the same cycle.
  assign accept = (state == ACC) && in_valid && !start;
  assign last   = accept && (cnt == LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start)     state_nxt = len_ok ? ACC : IDLE;
    else if (last) state_nxt = IDLE;
  end

  always_comb begin
    in_ready = (state == ACC);
  end

  // Stage p1: count and published results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      len_err   <= 1'b0;
      out       <= '0;
      ovf       <= '0;
    end else begin
      out_valid <= last;
      len_err   <= start && !len_ok;
      if (load)        cnt <= len;
      else if (accept) cnt <= cnt - LEN_W'(1);
      if (last) begin
        out <= res;
        ovf <= res_ovf;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    soml_accum_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W),
      .SAT    (SAT)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .clr (load),
      .add (accept),
      .sdi (sdi[i*DATA_W +: DATA_W]),
      .res (res[i*OUT_W +: OUT_W]),
      .ovf (res_ovf[i])
    );
  end

endmodule

// File: tb/tb_soml_accum.sv
// Bench for soml_accum: three configurations share one stimulus stream and are
// checked each cycle against an arithmetic model, plus hand-computed results.
module tb_soml_accum;

  localparam int DATA_W  = 16;
  localparam int LANES   = 4;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic in_valid = 1'b0;
  logic [LANES*DATA_W-1:0] sdi = '0;

  logic [LANES*20-1:0] out0;
  logic [LANES*16-1:0] out1, out2;
  logic [LANES-1:0] ovf0, ovf1, ovf2;
  logic rdy0, rdy1, rdy2, ov0, ov1, ov2, le0, le1, le2;

  always #5 clk = ~clk;

  soml_accum #(.DATA_W(DATA_W), .LANES(LANES), .MAX_LEN(MAX_LEN), .OUT_W(20), .SAT(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .sdi(sdi),
    .in_ready(rdy0), .out(out0), .ovf(ovf0), .out_valid(ov0), .len_err(le0));
  soml_accum #(.DATA_W(DATA_W), .LANES(LANES), .MAX_LEN(MAX_LEN), .OUT_W(16), .SAT(1)) u_sat16 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .sdi(sdi),
    .in_ready(rdy1), .out(out1), .ovf(ovf1), .out_valid(ov1), .len_err(le1));
  soml_accum #(.DATA_W(DATA_W), .LANES(LANES), .MAX_LEN(MAX_LEN), .OUT_W(16), .SAT(0)) u_wrap16 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .sdi(sdi),
    .in_ready(rdy2), .out(out2), .ovf(ovf2), .out_valid(ov2), .len_err(le2));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int ow_of(input int k);
    return (k == 0) ? 20 : 16;
  endfunction

  function automatic longint lane(input int k, input int i);
    case (k)
      0:       return longint'($signed(out0[i*20 +: 20]));
      1:       return longint'($signed(out1[i*16 +: 16]));
      default: return longint'($signed(out2[i*16 +: 16]));
    endcase
  endfunction

  function automatic logic [LANES-1:0] ovf_of(input int k);
    return (k == 0) ? ovf0 : (k == 1) ? ovf1 : ovf2;
  endfunction
  function automatic logic rdy_of(input int k);
    return (k == 0) ? rdy0 : (k == 1) ? rdy1 : rdy2;
  endfunction
  function automatic logic ov_of(input int k);
    return (k == 0) ? ov0 : (k == 1) ? ov1 : ov2;
  endfunction
  function automatic logic le_of(input int k);
    return (k == 0) ? le0 : (k == 1) ? le1 : le2;
  endfunction

  // Result conversion from the arithmetic definition: clamp, or modulo 2^ow.
  function automatic void conv(input longint s, input int ow, input bit sat,
                               output longint v, output bit o);
    longint hi, lo, m;
    hi = (longint'(1) << (ow - 1)) - 1;
    lo = -hi - 1;
    m  = longint'(1) << ow;
    if (sat) begin
      if (s > hi)      begin v = hi; o = 1'b1; end
      else if (s < lo) begin v = lo; o = 1'b1; end
      else             begin v = s;  o = 1'b0; end
    end else begin
      v = s % m;
      if (v < 0) v += m;
      if (v > hi) v -= m;
      o = (v != s);
    end
  endfunction

  // Behavioural model
  longint sum[LANES] = '{default: 0};
  int rem = 0;
  bit active = 1'b0;
  bit e_ready = 1'b0, e_valid = 1'b0, e_err = 1'b0;
  longint e_out[3][LANES] = '{default: '{default: 0}};
  bit e_ovf[3][LANES] = '{default: '{default: 1'b0}};

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      active = 1'b0; rem = 0; e_ready = 1'b0; e_valid = 1'b0; e_err = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        sum[i] = 0;
        for (int k = 0; k < 3; k++) begin e_out[k][i] = 0; e_ovf[k][i] = 1'b0; end
      end
    end else begin
      e_valid = 1'b0;
      e_err = 1'b0;
      if (start) begin
        if (int'(len) >= 1 && int'(len) <= MAX_LEN) begin
          active = 1'b1; rem = int'(len);
          for (int i = 0; i < LANES; i++) sum[i] = 0;
        end else begin
          active = 1'b0; e_err = 1'b1;
        end
      end else if (active && in_valid) begin
        for (int i = 0; i < LANES; i++) sum[i] += longint'($signed(sdi[i*DATA_W +: DATA_W]));
        rem--;
        if (rem == 0) begin
          active = 1'b0; e_valid = 1'b1;
          for (int k = 0; k < 3; k++)
            for (int i = 0; i < LANES; i++)
              conv(sum[i], ow_of(k), k != 2, e_out[k][i], e_ovf[k][i]);
        end
      end
      e_ready = active;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle comparison of every configuration against the model
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("u%0d.in_ready", k), longint'(rdy_of(k)), longint'(e_ready));
      check($sformatf("u%0d.out_valid", k), longint'(ov_of(k)), longint'(e_valid));
      check($sformatf("u%0d.len_err", k), longint'(le_of(k)), longint'(e_err));
      for (int i = 0; i < LANES; i++) begin
        check($sformatf("u%0d.out[%0d]", k, i), lane(k, i), e_out[k][i]);
        check($sformatf("u%0d.ovf[%0d]", k, i), longint'(ovf_of(k)[i]), longint'(e_ovf[k][i]));
      end
    end
  end

  // Captures of published results for the hand-computed checks
  longint cap[3][LANES];
  bit capo[3][LANES];
  int vcnt = 0, errcnt = 0, ov_cyc = 0;

  initial forever begin
    @(negedge clk);
    if (le0) errcnt++;
    if (ov0) begin vcnt++; ov_cyc = cyc; end
    for (int k = 0; k < 3; k++)
      if (ov_of(k))
        for (int i = 0; i < LANES; i++) begin
          cap[k][i] = lane(k, i);
          capo[k][i] = ovf_of(k)[i];
        end
  end

  function automatic logic [LANES*DATA_W-1:0] all4(input int x);
    logic [DATA_W-1:0] s;
    s = DATA_W'(x);
    return {LANES{s}};
  endfunction

  task automatic step(input logic s, input int l, input logic v, input logic [LANES*DATA_W-1:0] d);
    @(posedge clk);
    #1;
    start = s; len = LEN_W'(l); in_valid = v; sdi = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int t0, t1, v0, e0;
    longint basic_exp[LANES];
    basic_exp = '{700, 1400, 2100, 2800};

    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", longint'(rdy0), 0);
    check("reset_out", longint'(out0), 0);
    check("reset_out_valid", longint'(ov0), 0);
    check("reset_len_err", longint'(le0), 0);
    rst = 1'b0;
    step(0, 0, 0, '0);

    // Basic run
    step(1, 7, 0, '0);
    t0 = cyc; v0 = vcnt;
    repeat (7) step(0, 0, 1, {16'd400, 16'd300, 16'd200, 16'd100});
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    check("basic_latency", longint'(ov_cyc - t0), 8);
    check("basic_runs", longint'(vcnt - v0), 1);
    for (int i = 0; i < LANES; i++) begin
      check($sformatf("basic_lane%0d", i), cap[0][i], basic_exp[i]);
      check($sformatf("basic_ovf%0d", i), longint'(capo[0][i]), 0);
    end

    // Gapped input
    step(1, 3, 0, '0);
    t0 = cyc;
    step(0, 0, 1, all4(-5));
    step(0, 0, 0, all4(1000));
    step(0, 0, 0, all4(1000));
    check("gap_in_ready", longint'(rdy0), 1);
    step(0, 0, 1, all4(7));
    step(0, 0, 0, all4(1000));
    step(0, 0, 1, all4(-9));
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    check("gap_latency", longint'(ov_cyc - t0), 7);
    check("gap_result", cap[0][0], -7);

    // Positive saturation / wrap
    step(1, 16, 0, '0);
    repeat (16) step(0, 0, 1, all4(32'h7FFF));
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    check("satp_sat16", cap[1][0], 32767);
    check("satp_sat16_ovf", longint'(capo[1][0]), 1);
    check("satp_wrap16", cap[2][0], -16);
    check("satp_wrap16_ovf", longint'(capo[2][0]), 1);
    check("satp_w20", cap[0][0], 524272);
    check("satp_w20_ovf", longint'(capo[0][0]), 0);

    // Negative saturation / wrap
    step(1, 16, 0, '0);
    repeat (16) step(0, 0, 1, all4(32'h8000));
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    check("satn_sat16", cap[1][3], -32768);
    check("satn_sat16_ovf", longint'(capo[1][3]), 1);
    check("satn_wrap16", cap[2][3], 0);
    check("satn_wrap16_ovf", longint'(capo[2][3]), 1);
    check("satn_w20", cap[0][3], -524288);
    check("satn_w20_ovf", longint'(capo[0][3]), 0);

    // Abort and restart
    step(1, 5, 0, '0);
    v0 = vcnt;
    repeat (3) step(0, 0, 1, all4(10));
    step(1, 2, 1, all4(99));
    step(0, 0, 1, all4(4));
    step(0, 0, 1, all4(6));
    repeat (3) step(0, 0, 0, '0);
    check("abort_runs", longint'(vcnt - v0), 1);
    check("abort_result", cap[0][1], 10);

    // Illegal lengths
    e0 = errcnt; v0 = vcnt;
    step(1, 0, 0, '0);
    step(0, 0, 0, '0);
    check("illegal0_in_ready", longint'(rdy0), 0);
    step(1, MAX_LEN + 1, 0, '0);
    step(0, 0, 1, all4(3));
    check("illegal17_in_ready", longint'(rdy0), 0);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    check("illegal_err_pulses", longint'(errcnt - e0), 2);
    check("illegal_runs", longint'(vcnt - v0), 0);
    check("illegal_out_held", lane(0, 0), 10);

    // Asynchronous reset mid-run
    step(1, 4, 0, '0);
    v0 = vcnt;
    step(0, 0, 1, all4(5));
    step(0, 0, 1, all4(5));
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", longint'(rdy0), 0);
    check("rst_out", lane(0, 0), 0);
    check("rst_ovf", longint'(ovf1), 0);
    check("rst_out_valid", longint'(ov0), 0);
    step(0, 0, 1, all4(5));
    rst = 1'b0;
    repeat (4) step(0, 0, 1, all4(5));
    step(0, 0, 0, '0);
    check("rst_no_result", longint'(vcnt - v0), 0);

    // Back-to-back runs
    step(1, 2, 0, '0);
    t0 = cyc;
    step(0, 0, 1, all4(1));
    step(0, 0, 1, all4(2));
    step(1, 3, 0, '0);
    t1 = cyc;
    @(negedge clk);
    #1;
    check("b2b_first_latency", longint'(ov_cyc - t0), 3);
    check("b2b_first_result", cap[0][2], 3);
    step(0, 0, 1, all4(1));
    step(0, 0, 1, all4(2));
    step(0, 0, 1, all4(3));
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    check("b2b_second_latency", longint'(ov_cyc - t1), 4);
    check("b2b_second_result", cap[0][2], 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
